// File: rtl/led_pwm_multi_if.sv
// led_pwm_multi_if: control inputs and PWM/busy outputs of led_pwm_multi.
// master drives mode/level/sensor/presence/enables, slave returns pwm/busy.
interface led_pwm_multi_if #(
  parameter int CH = 4
);
  logic [3:0]    mode;
  logic [3:0]    manual_lvl;
  logic [15:0]   sensor;
  logic [9:0]    distancia;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] pwm;
  logic          busy;

  modport master (
    output mode, manual_lvl, sensor, distancia, ch_en,
    input  pwm, busy
  );

  modport slave (
    input  mode, manual_lvl, sensor, distancia, ch_en,
    output pwm, busy
  );
endinterface

// File: rtl/led_pwm_multi.sv
// led_pwm_multi: CH-channel LED PWM driver with manual/auto/presence targets.
// Define LED_PWM_FADE_EN for per-channel ramping FSMs and the busy flag.
module led_pwm_multi #(
  parameter int CH         = 4,
  parameter int PWM_W      = 9,
  parameter int PRESC      = 100,
  parameter int DIST_TH    = 100,
  parameter int AUTO_OFF   = 4500,
  parameter int AUTO_SHIFT = 3,
  parameter int FADE_STEP  = 1
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  led_pwm_multi_if.slave io
);

  localparam logic [PWM_W-1:0] MAX = {PWM_W{1'b1}};
  localparam logic [PWM_W-1:0] ONE = PWM_W'(1);
  localparam int PSW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PSW-1:0] P_LAST = PSW'(PRESC - 1);
  localparam logic [PSW-1:0] P_ONE = PSW'(1);
  localparam logic [PWM_W+3:0] NINE = (PWM_W+4)'(9);
  localparam logic [15:0] S_OFF = 16'(AUTO_OFF);
  localparam logic [9:0] D_TH = 10'(DIST_TH);

  logic [PSW-1:0]   r_presc;
  logic [PWM_W-1:0] r_cnt;
  logic             w_tick;
  logic             w_wrap;

  assign w_tick = (r_presc == P_LAST);
  assign w_wrap = w_tick && (r_cnt == MAX - ONE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_presc <= '0;
      r_cnt   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + P_ONE;
      if (w_wrap)
        r_cnt <= '0;
      else if (w_tick)
        r_cnt <= r_cnt + ONE;
    end
  end

  logic [3:0]       w_lvl;
  logic [15:0]      w_sh;
  logic [PWM_W-1:0] w_man;
  logic [PWM_W-1:0] w_auto;
  logic [PWM_W-1:0] w_t;
  logic             w_near;
  logic             w_sel_man;
  logic             w_sel_auto;

  assign w_lvl = (io.manual_lvl > 4'd9) ? 4'd9 : io.manual_lvl;
  assign w_man = PWM_W'(({4'd0, MAX} * {{PWM_W{1'b0}}, w_lvl}) / NINE);
  assign w_sh  = io.sensor >> AUTO_SHIFT;
  // bright ambient or a large shifted reading both clamp to dark
  assign w_auto = (io.sensor > S_OFF || w_sh > 16'(MAX)) ? '0
                : MAX - w_sh[PWM_W-1:0];

  assign w_near     = (io.distancia < D_TH);
  assign w_sel_man  = w_near && (io.mode == 4'b0010);
  assign w_sel_auto = w_near && (io.mode == 4'b0001);

  always_comb begin
    w_t = '0;
    unique case (1'b1)
      w_sel_man:  w_t = w_man;
      w_sel_auto: w_t = w_auto;
      default:    w_t = '0;
    endcase
  end

`ifdef LED_PWM_FADE_EN
  typedef enum logic [1:0] {ST_STEADY, ST_UP, ST_DN} st_t;
  localparam logic [PWM_W-1:0] STEP = PWM_W'(FADE_STEP);
  logic [CH-1:0] w_bsy;
`endif

  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [PWM_W-1:0] r_cur;
    logic [PWM_W-1:0] r_tgt;
    logic [PWM_W-1:0] w_cur_n;
    logic [PWM_W-1:0] w_tgt_n;
    logic             r_pwm;

    assign w_tgt_n = io.ch_en[g] ? w_t : '0;

`ifdef LED_PWM_FADE_EN
    st_t              r_st;
    st_t              w_st_n;
    logic [PWM_W-1:0] w_gap;
    logic [PWM_W-1:0] w_dlt;

    assign w_gap = (r_st == ST_DN) ? r_cur - r_tgt : r_tgt - r_cur;
    assign w_dlt = (w_gap < STEP) ? w_gap : STEP;

    // step toward the old target, then classify against the new one
    always_comb begin
      w_cur_n = r_cur;
      w_st_n  = ST_STEADY;
      unique case (r_st)
        ST_UP:   w_cur_n = r_cur + w_dlt;
        ST_DN:   w_cur_n = r_cur - w_dlt;
        default: w_cur_n = r_cur;
      endcase
      if (w_cur_n < w_tgt_n)
        w_st_n = ST_UP;
      else if (w_cur_n > w_tgt_n)
        w_st_n = ST_DN;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n)
        r_st <= ST_STEADY;
      else if (w_wrap)
        r_st <= w_st_n;
    end

    assign w_bsy[g] = (r_st != ST_STEADY);
`else
    assign w_cur_n = r_tgt;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        r_cur <= '0;
        r_tgt <= '0;
        r_pwm <= 1'b0;
      end else begin
        r_pwm <= (r_cnt < r_cur);
        if (w_wrap) begin
          r_cur <= w_cur_n;
          r_tgt <= w_tgt_n;
        end
      end
    end

    assign io.pwm[g] = r_pwm;
  end

`ifdef LED_PWM_FADE_EN
  logic r_busy;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      r_busy <= 1'b0;
    else
      r_busy <= |w_bsy;
  end

  assign io.busy = r_busy;
`else
  assign io.busy = 1'b0;
`endif

endmodule

// File: tb/tb_led_pwm_multi.sv
// tb_led_pwm_multi: randomized and directed bench for led_pwm_multi.
// Reference model tracks duty/target per channel in plain integers.
module tb_led_pwm_multi;
  localparam int CH = 2;
  localparam int MX = 15;
  localparam int FS = 2;
`ifdef LED_PWM_FADE_EN
  localparam bit FADE = 1'b1;
`else
  localparam bit FADE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  led_pwm_multi_if #(.CH(CH)) io ();

  led_pwm_multi #(
    .CH(CH), .PWM_W(4), .PRESC(1), .DIST_TH(100),
    .AUTO_OFF(4500), .AUTO_SHIFT(3), .FADE_STEP(FS)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .io(io)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  int m_slot;
  int m_cur [CH];
  int m_tgt [CH];

  function automatic int target(logic [3:0] md, logic [3:0] lv,
                                logic [15:0] s, logic [9:0] d);
    int l;
    int sh;
    if (int'(d) >= 100) return 0;
    if (md == 4'b0010) begin
      l = (int'(lv) > 9) ? 9 : int'(lv);
      return (l * MX) / 9;
    end
    if (md == 4'b0001) begin
      if (int'(s) > 4500) return 0;
      sh = int'(s) / 8;
      return MX - ((sh > MX) ? MX : sh);
    end
    return 0;
  endfunction

  function automatic int fade(int c, int t);
    int d;
    if (!FADE) return t;
    d = t - c;
    if (d > FS) d = FS;
    if (d < -FS) d = -FS;
    return c + d;
  endfunction

  task automatic mreset();
    m_slot = 0;
    for (int i = 0; i < CH; i++) begin
      m_cur[i] = 0;
      m_tgt[i] = 0;
    end
  endtask

  // expectations from pre-edge model state, then one clock
  task automatic cyc(output logic [CH-1:0] ep, output logic eb);
    int t;
    eb = 1'b0;
    for (int i = 0; i < CH; i++) begin
      ep[i] = (m_slot < m_cur[i]);
      if (FADE && m_cur[i] != m_tgt[i]) eb = 1'b1;
    end
    if (m_slot == MX - 1) begin
      t = target(io.mode, io.manual_lvl, io.sensor, io.distancia);
      for (int i = 0; i < CH; i++) begin
        m_cur[i] = fade(m_cur[i], m_tgt[i]);
        m_tgt[i] = io.ch_en[i] ? t : 0;
      end
      m_slot = 0;
    end else begin
      m_slot++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_period(output int hi [CH], output int bad);
    logic [CH-1:0] ep;
    logic eb;
    bad = 0;
    for (int i = 0; i < CH; i++) hi[i] = 0;
    while (m_slot != 0) begin
      cyc(ep, eb);
      if (io.pwm !== ep || io.busy !== eb) bad++;
    end
    repeat (MX) begin
      cyc(ep, eb);
      if (io.pwm !== ep || io.busy !== eb) bad++;
      for (int i = 0; i < CH; i++) hi[i] += int'(io.pwm[i]);
    end
  endtask

  task automatic test_reset();
    io.mode = 4'b0010;
    io.manual_lvl = 4'd9;
    io.sensor = 16'd0;
    io.distancia = 10'd50;
    io.ch_en = 2'b11;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_run++;
    if (io.pwm !== 2'b00 || io.busy !== 1'b0)
      $display("FAIL reset_hold: pwm=%b busy=%b want 00/0", io.pwm, io.busy);
    if (io.pwm !== 2'b00 || io.busy !== 1'b0) n_fail++;
    mreset();
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_up();
    int hi [CH];
    int bad;
    int e;
    for (int k = 0; k <= 10; k++) begin
      run_period(hi, bad);
      e = (k < 2) ? 0 : (FADE ? ((2 * (k - 1) > MX) ? MX : 2 * (k - 1)) : MX);
      n_run++;
      if (hi[0] !== e || hi[1] !== e || bad !== 0) begin
        n_fail++;
        $display("FAIL ramp_up p%0d: duty %0d/%0d bad=%0d want %0d bad=0",
                 k, hi[0], hi[1], bad, e);
      end
      if (k == 4) begin
        n_run++;
        if (io.busy !== FADE) begin
          n_fail++;
          $display("FAIL ramp_busy: busy=%b want %b", io.busy, FADE);
        end
      end
    end
    n_run++;
    if (io.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_done_busy: busy=%b want 0", io.busy);
    end
  endtask

  task automatic test_manual();
    int hi [CH];
    int bad;
    int acc = 0;
    io.manual_lvl = 4'd3;
    repeat (10) begin
      run_period(hi, bad);
      acc += bad;
    end
    run_period(hi, bad);
    acc += bad;
    n_run++;
    if (hi[0] !== 5 || hi[1] !== 5 || acc !== 0) begin
      n_fail++;
      $display("FAIL manual_lvl3: duty %0d/%0d bad=%0d want 5/5 bad=0",
               hi[0], hi[1], acc);
    end
  endtask

  task automatic test_auto();
    int hi [CH];
    int bad;
    int acc;
    int e;
    io.mode = 4'b0001;
    for (int r = 0; r < 5; r++) begin
      io.sensor = (r == 0) ? 16'd40
                : (r == 4) ? 16'd4501 : 16'($urandom_range(0, 200));
      e = target(io.mode, io.manual_lvl, io.sensor, io.distancia);
      acc = 0;
      repeat (10) begin
        run_period(hi, bad);
        acc += bad;
      end
      run_period(hi, bad);
      acc += bad;
      if (r == 0) e = 10;
      if (r == 4) e = 0;
      n_run++;
      if (hi[0] !== e || hi[1] !== e || acc !== 0) begin
        n_fail++;
        $display("FAIL auto s=%0d: duty %0d/%0d bad=%0d want %0d bad=0",
                 io.sensor, hi[0], hi[1], acc, e);
      end
    end
  endtask

  task automatic test_presence();
    int hi [CH];
    int bad;
    int acc = 0;
    int e;
    logic [CH-1:0] ep;
    logic eb;
    logic hold;
    io.mode = 4'b0010;
    io.manual_lvl = 4'd9;
    io.distancia = 10'd50;
    repeat (11) begin
      run_period(hi, bad);
      acc += bad;
    end
    n_run++;
    if (hi[0] !== 15 || hi[1] !== 15) begin
      n_fail++;
      $display("FAIL presence_lit: duty %0d/%0d want 15", hi[0], hi[1]);
    end
    repeat (7) begin
      cyc(ep, eb);
      if (io.pwm !== ep || io.busy !== eb) acc++;
    end
    io.distancia = 10'd120;
    hold = 1'b1;
    while (m_slot != 0) begin
      cyc(ep, eb);
      if (io.pwm !== ep || io.busy !== eb) acc++;
      if (io.pwm !== 2'b11) hold = 1'b0;
    end
    n_run++;
    if (hold !== 1'b1) begin
      n_fail++;
      $display("FAIL presence_hold: pwm changed mid-period, want 11");
    end
    run_period(hi, bad);
    acc += bad;
    n_run++;
    if (hi[0] !== 15 || hi[1] !== 15) begin
      n_fail++;
      $display("FAIL presence_latency: duty %0d/%0d want 15", hi[0], hi[1]);
    end
    run_period(hi, bad);
    acc += bad;
    e = FADE ? 13 : 0;
    n_run++;
    if (hi[0] !== e || hi[1] !== e) begin
      n_fail++;
      $display("FAIL presence_ramp: duty %0d/%0d want %0d", hi[0], hi[1], e);
    end
    repeat (8) begin
      run_period(hi, bad);
      acc += bad;
    end
    n_run++;
    if (hi[0] !== 0 || hi[1] !== 0 || acc !== 0) begin
      n_fail++;
      $display("FAIL presence_off: duty %0d/%0d bad=%0d want 0 bad=0",
               hi[0], hi[1], acc);
    end
  endtask

  task automatic test_ch_en();
    int hi [CH];
    int bad;
    int acc = 0;
    int e;
    io.distancia = 10'd50;
    io.ch_en = 2'b11;
    repeat (11) begin
      run_period(hi, bad);
      acc += bad;
    end
    io.ch_en = 2'b01;
    for (int j = 0; j < 10; j++) begin
      run_period(hi, bad);
      acc += bad;
      e = (j < 2) ? 15 : (FADE ? ((15 - 2 * (j - 1) < 0) ? 0 : 15 - 2 * (j - 1)) : 0);
      n_run++;
      if (hi[0] !== 15 || hi[1] !== e) begin
        n_fail++;
        $display("FAIL ch_en p%0d: duty %0d/%0d want 15/%0d", j, hi[0], hi[1], e);
      end
    end
    n_run++;
    if (acc !== 0) begin
      n_fail++;
      $display("FAIL ch_en_model: bad=%0d want 0", acc);
    end
  endtask

  task automatic test_reset_mid();
    int hi [CH];
    int bad;
    int e;
    logic [CH-1:0] ep;
    logic eb;
    io.ch_en = 2'b11;
    repeat (3) run_period(hi, bad);
    repeat (5) cyc(ep, eb);
    #2;
    rst_n = 1'b0;
    #1;
    n_run++;
    if (io.pwm !== 2'b00 || io.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: pwm=%b busy=%b want 00/0", io.pwm, io.busy);
    end
    @(posedge clk);
    #1;
    n_run++;
    if (io.pwm !== 2'b00 || io.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clocked: pwm=%b busy=%b want 00/0", io.pwm, io.busy);
    end
    mreset();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_period(hi, bad);
      e = (k < 2) ? 0 : (FADE ? 2 * (k - 1) : 15);
      n_run++;
      if (hi[0] !== e || hi[1] !== e || bad !== 0) begin
        n_fail++;
        $display("FAIL restart p%0d: duty %0d/%0d bad=%0d want %0d bad=0",
                 k, hi[0], hi[1], bad, e);
      end
    end
  endtask

  task automatic test_random();
    int hi [CH];
    int bad;
    logic [CH-1:0] ep;
    logic eb;
    logic [3:0] modes [4] = '{4'b0010, 4'b0001, 4'b0000, 4'b0110};
    for (int it = 0; it < 30; it++) begin
      bad = 0;
      repeat (2) begin
        repeat ($urandom_range(0, 20)) begin
          cyc(ep, eb);
          if (io.pwm !== ep || io.busy !== eb) bad++;
        end
        io.mode = modes[$urandom_range(0, 3)];
        io.manual_lvl = 4'($urandom_range(0, 15));
        io.sensor = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(4400, 4600))
                                                : 16'($urandom_range(0, 200));
        io.distancia = 10'($urandom_range(0, 150));
        io.ch_en = 2'($urandom_range(0, 3));
      end
      n_run++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL random it%0d: %0d cycles off model, want 0", it, bad);
      end
      run_period(hi, bad);
      n_run++;
      if (bad !== 0) begin
        n_fail++;
        $display("FAIL random_per it%0d: %0d cycles off model, want 0", it, bad);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_manual();
    test_auto();
    test_presence();
    test_ch_en();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
